// File: rtl/sink_arb_pkg.sv
// ============================================================================
// sink_arb_pkg
// Shared types and constants for the sink FIFO write arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sink_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int DATA_W  = 512;
    localparam int LEN_W   = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sink_rr_pick.sv
// ============================================================================
// sink_rr_pick
// Combinational round-robin winner search starting just above last_grant.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sink_rr_pick
    import sink_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    int                 w_idx;
    logic [NUM_REQ-1:0] w_shifted;

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        w_idx     = 0;
        w_shifted = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = int'(last_grant) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_shifted = req_mask >> w_idx;
            if (w_shifted[0]) begin
                winner    = IDX_W'(w_idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sink_fifo_wr_arb.sv
// ============================================================================
// sink_fifo_wr_arb
// Round-robin burst arbiter feeding a sink FIFO write port with room check.
// Optional statistics counters enabled by macro SINK_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sink_fifo_wr_arb
    import sink_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int MARGIN     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_we,
    input  logic [31:0]               fifo_wr_count,
    input  logic                      fifo_full,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      err_zero_len,
    output logic [NUM_REQ*32-1:0]     beat_cnt,
    output logic [31:0]               stall_cnt
);

    arb_state_t         r_state;
    logic [LEN_W-1:0]   r_left;
    logic [IDX_W-1:0]   r_last;

    logic [NUM_REQ-1:0] w_len_nz;
    logic [NUM_REQ-1:0] w_mask;
    logic               w_zero_hit;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic [LEN_W-1:0]   w_win_len;
    logic [32:0]        w_need;
    logic               w_room;
    logic               w_g_valid;
    logic [DATA_W-1:0]  w_g_data;
    logic               w_beat;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len_nz
        assign w_len_nz[i] = |req_len[i*LEN_W +: LEN_W];
    end

    assign w_mask     = req_valid & w_len_nz;
    assign w_zero_hit = |(req_valid & ~w_len_nz);

    sink_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_mask   (w_mask),
        .last_grant (r_last),
        .winner     (w_winner),
        .any_valid  (w_any)
    );

    always_comb begin
        w_win_len = '0;
        w_g_valid = 1'b0;
        w_g_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == w_winner) begin
                w_win_len = req_len[i*LEN_W +: LEN_W];
            end
            if (IDX_W'(i) == grant_id) begin
                w_g_valid = req_valid[i];
                w_g_data  = req_data[i*DATA_W +: DATA_W];
                if (r_state == ST_BURST) begin
                    req_ready[i] = !fifo_full;
                end
            end
        end
    end

    // 33-bit sum so a near-wrapped write count cannot fake free room.
    assign w_need = {1'b0, fifo_wr_count} + 33'(w_win_len) + 33'(MARGIN);
    assign w_room = (w_need <= 33'(FIFO_DEPTH));
    assign w_beat = (r_state == ST_BURST) && w_g_valid && !fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_left       <= '0;
            r_last       <= IDX_W'(NUM_REQ - 1);
            fifo_we      <= 1'b0;
            fifo_din     <= '0;
            busy         <= 1'b0;
            grant_id     <= '0;
            err_zero_len <= 1'b0;
        end else begin
            fifo_we <= w_beat;
            if (w_beat) begin
                fifo_din <= w_g_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_zero_hit) begin
                        err_zero_len <= 1'b1;
                    end
                    // Head-of-line: a winner without room blocks everyone.
                    if (w_any && w_room) begin
                        r_left   <= w_win_len;
                        grant_id <= w_winner;
                        busy     <= 1'b1;
                        r_state  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_beat) begin
                        r_left <= r_left - LEN_W'(1);
                        if (r_left == LEN_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_last  <= grant_id;
                            busy    <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SINK_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any && !w_room) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_beat && (IDX_W'(i) == grant_id)) begin
                    beat_cnt[i*32 +: 32] <= beat_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`else
    assign beat_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
